ram1_arbiter: RTL and testbench

- Shares the single off-chip SRAM (Ram1) between two requesters: the instruction-fetch port (IF) and the load/store port (MEM).
- Sequences the SRAM control pins with fixed multi-cycle read and write timing.
- Sits between the CPU pipeline and the Ram1 pins. The pipeline stalls on a port until that port's ack pulses.

---
 rtl/zz_ram_pkg.sv | 34 +++
 rtl/ram1_phy.sv | 82 ++++++++
 rtl/ram1_arbiter.sv | 139 +++++++++++++
 tb/tb_ram1_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/zz_ram_pkg.sv
// ============================================================================
// Module      : zz_ram_pkg
// Description : Shared encodings for the Ram1 arbiter and its pin-level PHY.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zz_ram_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_RD_SETUP  = 4'd1;
    localparam logic [3:0] ST_RD_SAMPLE = 4'd2;
    localparam logic [3:0] ST_WR_SETUP  = 4'd3;
    localparam logic [3:0] ST_WR_PULSE  = 4'd4;
    localparam logic [3:0] ST_WR_HOLD   = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_RD_SETUP  = ST_RD_SETUP,
        S_RD_SAMPLE = ST_RD_SAMPLE,
        S_WR_SETUP  = ST_WR_SETUP,
        S_WR_PULSE  = ST_WR_PULSE,
        S_WR_HOLD   = ST_WR_HOLD
    } state_t;

    localparam logic CTRL_ON  = 1'b0;
    localparam logic CTRL_OFF = 1'b1;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram1_phy.sv
// ============================================================================
// Module      : ram1_phy
// Description : Registered Ram1 pin drivers, tristate data buffer and
//               per-port read-data capture registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram1_phy
    import zz_ram_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  state_t            i_state,
    input  state_t            i_next,
    input  logic              i_cap_sel,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_oe,
    output logic              o_ram_we,
    output logic              o_ram_en,
    inout  wire  [DATA_W-1:0] io_ram_data,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic [DATA_W-1:0] o_mem_rdata
);

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_oe;
    logic              r_we;
    logic              r_en;
    logic              r_drive;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    // Controls are registered from the next state so each pin changes in
    // the same cycle the FSM enters the corresponding phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_oe        <= CTRL_OFF;
            r_we        <= CTRL_OFF;
            r_en        <= CTRL_OFF;
            r_drive     <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (i_load) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            r_en    <= (i_next == S_IDLE) ? CTRL_OFF : CTRL_ON;
            r_oe    <= (i_next == S_RD_SETUP || i_next == S_RD_SAMPLE) ? CTRL_ON : CTRL_OFF;
            r_we    <= (i_next == S_WR_PULSE) ? CTRL_ON : CTRL_OFF;
            r_drive <= (i_next == S_WR_SETUP || i_next == S_WR_PULSE || i_next == S_WR_HOLD);
            if (i_state == S_RD_SAMPLE) begin
                if (i_cap_sel == REQ_IF) begin
                    r_if_rdata <= io_ram_data;
                end else begin
                    r_mem_rdata <= io_ram_data;
                end
            end
        end
    end

    assign io_ram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign o_ram_addr  = r_addr;
    assign o_ram_oe    = r_oe;
    assign o_ram_we    = r_we;
    assign o_ram_en    = r_en;
    assign o_if_rdata  = r_if_rdata;
    assign o_mem_rdata = r_mem_rdata;

endmodule

`default_nettype wire

// File: rtl/ram1_arbiter.sv
// ============================================================================
// Module      : ram1_arbiter
// Description : Shares Ram1 between instruction fetch and load/store with
//               MEM priority, starvation relief for IF and fixed SRAM timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram1_arbiter
    import zz_ram_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] Ram1Addr,
    inout  wire  [DATA_W-1:0] Ram1Data,
    output logic              Ram1OE,
    output logic              Ram1WE,
    output logic              Ram1EN
);

    localparam int                CNT_W        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_next;
    logic              r_id;
    logic [CNT_W-1:0]  r_starve;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic              r_busy;
    logic              w_grant_if;
    logic              w_grant_mem;
    logic              w_if_eff;
    logic              w_mem_eff;
    logic [ADDR_W-1:0] w_addr;

    always_comb begin
        w_next      = r_state;
        w_grant_if  = 1'b0;
        w_grant_mem = 1'b0;
        // A port's request is still high during its own ack cycle.
        w_if_eff    = if_req  && !r_if_ack;
        w_mem_eff   = mem_req && !r_mem_ack;
        case (r_state)
            S_IDLE: begin
                if (w_if_eff && r_starve == c_STARVE_MAX) begin
                    w_grant_if = 1'b1;
                end else if (w_mem_eff) begin
                    w_grant_mem = 1'b1;
                end else if (w_if_eff) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_if) begin
                    w_next = S_RD_SETUP;
                end else if (w_grant_mem) begin
                    w_next = mem_we ? S_WR_SETUP : S_RD_SETUP;
                end
            end
            S_RD_SETUP:  w_next = S_RD_SAMPLE;
            S_RD_SAMPLE: w_next = S_IDLE;
            S_WR_SETUP:  w_next = S_WR_PULSE;
            S_WR_PULSE:  w_next = S_WR_HOLD;
            S_WR_HOLD:   w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    assign w_addr = w_grant_if ? if_addr : mem_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_id      <= REQ_IF;
            r_starve  <= '0;
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != S_IDLE);
            r_if_ack  <= (r_state == S_RD_SAMPLE) && (r_id == REQ_IF);
            r_mem_ack <= ((r_state == S_RD_SAMPLE) && (r_id == REQ_MEM)) || (r_state == S_WR_HOLD);
            if (w_grant_if) begin
                r_id     <= REQ_IF;
                r_starve <= '0;
            end else if (w_grant_mem) begin
                r_id <= REQ_MEM;
                if (!if_req) begin
                    r_starve <= '0;
                end else if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + CNT_W'(1);
                end
            end
        end
    end

    ram1_phy #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_phy (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_grant_if | w_grant_mem),
        .i_addr      (w_addr),
        .i_wdata     (mem_wdata),
        .i_state     (r_state),
        .i_next      (w_next),
        .i_cap_sel   (r_id),
        .o_ram_addr  (Ram1Addr),
        .o_ram_oe    (Ram1OE),
        .o_ram_we    (Ram1WE),
        .o_ram_en    (Ram1EN),
        .io_ram_data (Ram1Data),
        .o_if_rdata  (if_rdata),
        .o_mem_rdata (mem_rdata)
    );

    assign if_ack  = r_if_ack;
    assign mem_ack = r_mem_ack;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ram1_arbiter.sv
// ============================================================================
// Module      : tb_ram1_arbiter
// Description : Directed vector bench for ram1_arbiter with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram1_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic [AW-1:0] Ram1Addr;
    tri1  [DW-1:0] Ram1Data;
    logic          Ram1OE;
    logic          Ram1WE;
    logic          Ram1EN;

    always #5 clk = ~clk;

    ram1_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
        .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN)
    );

    // SRAM model: drives the bus while selected with OE low, writes on WE low.
    logic [DW-1:0] sram [0:1023];
    assign Ram1Data = (!Ram1EN && !Ram1OE) ? sram[Ram1Addr[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!Ram1EN && !Ram1WE) sram[Ram1Addr[9:0]] <= Ram1Data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("oe_we_overlap", 32'(Ram1OE | Ram1WE), 1);
            if (!Ram1OE) chk("rd_bus_value", 32'(Ram1Data), 32'(sram[Ram1Addr[9:0]]));
        end
    end

    typedef struct {
        bit            is_if;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs [9];
    logic [DW-1:0] hold_if  = '0;
    logic [DW-1:0] hold_mem = '0;
    int            seq_k    [10];
    bit            seq_port [10];

    task automatic run_vec(input vec_t v, input int idx);
        bit   done = 1'b0;
        logic ack;
        @(posedge clk); #1;
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
        end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (k == 1) chk($sformatf("v%0d_busy", idx), 32'(busy), 1);
            if (v.we && k >= 1 && k <= 3) begin
                chk($sformatf("v%0d_wr_bus", idx), 32'(Ram1Data), 32'(v.wdata));
                chk($sformatf("v%0d_wr_we", idx), 32'(Ram1WE), (k == 2) ? 0 : 1);
                chk($sformatf("v%0d_wr_addr", idx), 32'(Ram1Addr), 32'(v.addr));
            end
            if (!v.we && (k == 1 || k == 2)) begin
                chk($sformatf("v%0d_rd_oe", idx), 32'(Ram1OE), 0);
                chk($sformatf("v%0d_rd_addr", idx), 32'(Ram1Addr), 32'(v.addr));
            end
            ack = v.is_if ? if_ack : mem_ack;
            if (ack) begin
                done = 1'b1;
                chk($sformatf("v%0d_latency", idx), k, v.we ? 4 : 3);
                if (!v.we) chk($sformatf("v%0d_rdata", idx),
                               32'(v.is_if ? if_rdata : mem_rdata), 32'(v.exp));
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        if (!done) chk($sformatf("v%0d_ack_timeout", idx), 0, 1);
        if (!v.we) begin
            if (v.is_if) hold_if = v.exp; else hold_mem = v.exp;
        end
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_hold_if", idx), 32'(if_rdata), 32'(hold_if));
        chk($sformatf("v%0d_hold_mem", idx), 32'(mem_rdata), 32'(hold_mem));
        chk($sformatf("v%0d_idle", idx), {busy, Ram1EN, Ram1Data}, {1'b0, 1'b1, 16'hFFFF});
    endtask

    // Records which port acks (1 = IF) and in which cycle after both requests rise.
    task automatic watch(input int n, input bit toggle_if, input logic [DW-1:0] e_if,
                         input logic [DW-1:0] e_mem);
        int got = 0;
        int k = 0;
        while (got < n && k < 200) begin
            @(negedge clk);
            if (if_ack || mem_ack) begin
                chk("ack_exclusive", 32'(if_ack & mem_ack), 0);
                if (if_ack) chk("seq_if_data", 32'(if_rdata), 32'(e_if));
                else        chk("seq_mem_data", 32'(mem_rdata), 32'(e_mem));
                seq_port[got] = if_ack;
                seq_k[got]    = k;
                got++;
            end
            if (toggle_if) if_req = !mem_ack;
            if (got == n) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
            k++;
        end
        chk("seq_complete", got, n);
    endtask

    initial begin
        int exp_k_starve [10] = '{3, 7, 11, 15, 19, 22, 26, 30, 34, 38};
        bit exp_p_starve [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        for (int i = 0; i < 1024; i++) sram[i] = 16'(i) ^ 16'h5A00;
        sram[10'h020] = 16'h1234;

        vecs[0] = '{is_if: 0, we: 1, addr: 18'h00010, wdata: 16'hBEEF, exp: 16'h0000};
        vecs[1] = '{is_if: 0, we: 0, addr: 18'h00010, wdata: 16'h0000, exp: 16'hBEEF};
        vecs[2] = '{is_if: 1, we: 0, addr: 18'h00020, wdata: 16'h0000, exp: 16'h1234};
        vecs[3] = '{is_if: 0, we: 1, addr: 18'h003FF, wdata: 16'hA5A5, exp: 16'h0000};
        vecs[4] = '{is_if: 0, we: 0, addr: 18'h003FF, wdata: 16'h0000, exp: 16'hA5A5};
        vecs[5] = '{is_if: 1, we: 0, addr: 18'h003FF, wdata: 16'h0000, exp: 16'hA5A5};
        vecs[6] = '{is_if: 0, we: 0, addr: 18'h00020, wdata: 16'h0000, exp: 16'h1234};
        vecs[7] = '{is_if: 0, we: 1, addr: 18'h00000, wdata: 16'h0001, exp: 16'h0000};
        vecs[8] = '{is_if: 1, we: 0, addr: 18'h00000, wdata: 16'h0000, exp: 16'h0001};

        repeat (2) @(negedge clk);
        chk("rst_ctrl", {Ram1EN, Ram1OE, Ram1WE, busy, if_ack, mem_ack}, 6'b111000);
        chk("rst_bus", 32'(Ram1Data), 32'hFFFF);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ctrl", {Ram1EN, Ram1OE, Ram1WE, busy}, 4'b1110);
            chk("idle_bus", 32'(Ram1Data), 32'hFFFF);
            chk("idle_regs", {Ram1Addr, if_rdata, mem_rdata}, 0);
        end

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Starvation relief: IF drops its request only while MEM is being acked.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 18'h00020;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00010;
        watch(10, 1'b1, 16'h1234, 16'hBEEF);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve_port%0d", i), 32'(seq_port[i]), 32'(exp_p_starve[i]));
            chk($sformatf("starve_cycle%0d", i), seq_k[i], exp_k_starve[i]);
        end

        // Both held: each ack cycle hands the bus to the other port with no gap.
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b1; mem_req = 1'b1;
        watch(4, 1'b0, 16'h1234, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("alt_port%0d", i), 32'(seq_port[i]), 32'(i % 2));
            chk($sformatf("alt_cycle%0d", i), seq_k[i], 3 * (i + 1));
        end
        chk("if_rdata_stable", 32'(if_rdata), 32'h1234);

        // Reset asserted while WE is low.
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00040; mem_wdata = 16'h7777;
        repeat (3) @(negedge clk);
        chk("pre_rst_we", 32'(Ram1WE), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {Ram1EN, Ram1OE, Ram1WE, busy, mem_ack}, 5'b11100);
        chk("mid_rst_bus", 32'(Ram1Data), 32'hFFFF);
        chk("mid_rst_rdata", {if_rdata, mem_rdata}, 0);
        mem_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_noack", {mem_ack, if_ack, busy}, 0);
        end
        chk("aborted_write", 32'(sram[10'h040]), 32'(16'h0040 ^ 16'h5A00));
        hold_if = '0; hold_mem = '0;
        run_vec('{is_if: 0, we: 1, addr: 18'h00040, wdata: 16'h7777, exp: 16'h0000}, 20);
        run_vec('{is_if: 0, we: 0, addr: 18'h00040, wdata: 16'h0000, exp: 16'h7777}, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
